// File: rtl/fade_pkg.sv
// Shared types for the RGB colour-wheel fade: hue segments and sequencer states.
// Latency: n/a (types and a pure helper function only).
// Backpressure: n/a.
package fade_pkg;

  // Number of hue segments around the wheel.
  localparam int unsigned SEG_COUNT = 6;

  // Each segment ramps exactly one channel up or down.
  typedef enum logic [2:0] {
    SEG_R2Y = 3'd0,  // green rises
    SEG_Y2G = 3'd1,  // red falls
    SEG_G2C = 3'd2,  // blue rises
    SEG_C2B = 3'd3,  // green falls
    SEG_B2M = 3'd4,  // red rises
    SEG_M2R = 3'd5   // blue falls, then the wheel wraps
  } seg_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    OFFER = 2'd2
  } seq_state_t;

  // Next segment, rolling the last segment back to the first.
  function automatic seg_t next_seg(input seg_t s);
    seg_t n;
    if (s == SEG_M2R) n = SEG_R2Y;
    else              n = seg_t'(s + 3'd1);
    return n;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider producing a one-cycle tick every DIV enabled cycles.
// Latency: tick asserted combinationally while the count sits at DIV-1.
// Backpressure: none; the counter is held cleared while en is low.
//
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   en         : count enable; 0 clears and holds the counter
//   tick       : high for the single cycle the count equals DIV-1
module tick_prescaler #(
  parameter int unsigned DIV = 20000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);

  localparam int unsigned     CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n || !en) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Gated by en so a disabled prescaler can never tick, even when DIV is 1.
  assign tick = en && (cnt == LAST);

endmodule

// File: rtl/rgb_wheel_sequencer.sv
// Colour-wheel fade sequencer: prescaled step ticks walk a six-segment hue FSM
// and offer each new R/G/B duty triple to the PWM bank.
// Latency: tick or step in cycle N -> duties, upd_valid, seg, wheel_wrap after edge N+1.
// Backpressure: the offer is held stable until upd_ready; ticks arriving meanwhile are dropped and flagged on overrun.
//
// Ports:
//   clk, rst_n              : clock, synchronous active-low reset
//   run                     : 1 = free-running fade, 0 = paused
//   step                    : single-cycle advance request, honoured only while paused and idle
//   ovr_clr                 : clears the sticky overrun flag (a simultaneous set wins)
//   upd_valid / upd_ready   : duty-triple handshake towards the PWM bank
//   duty_r, duty_g, duty_b  : duty targets, 0..PWM_INTERVAL
//   seg                     : current hue segment 0..5
//   wheel_wrap              : one-cycle pulse alongside the offer that rolls segment 5 -> 0
//   overrun                 : sticky, a tick was dropped while an offer was pending
module rgb_wheel_sequencer
  import fade_pkg::*;
#(
  parameter int unsigned PWM_INTERVAL  = 1200,
  // Must divide PWM_INTERVAL exactly so a full wheel lands back on R=max, G=B=0.
  parameter int unsigned STEPS_PER_SEG = 100,
  parameter int unsigned TICK_DIV      = 20000,
  parameter int unsigned DUTY_W        = $clog2(PWM_INTERVAL + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic              step,
  input  logic              ovr_clr,
  input  logic              upd_ready,
  output logic              upd_valid,
  output logic [DUTY_W-1:0] duty_r,
  output logic [DUTY_W-1:0] duty_g,
  output logic [DUTY_W-1:0] duty_b,
  output logic [2:0]        seg,
  output logic              wheel_wrap,
  output logic              overrun
);

  localparam int unsigned      INC   = PWM_INTERVAL / STEPS_PER_SEG;
  localparam logic [DUTY_W:0]   INC_X = (DUTY_W + 1)'(INC);
  localparam logic [DUTY_W:0]   MAX_X = (DUTY_W + 1)'(PWM_INTERVAL);
  localparam logic [DUTY_W-1:0] MAX_D = DUTY_W'(PWM_INTERVAL);

  localparam int unsigned       IDX_W    = (STEPS_PER_SEG > 1) ? $clog2(STEPS_PER_SEG) : 1;
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(STEPS_PER_SEG - 1);

  typedef struct packed {
    logic [DUTY_W-1:0] r;
    logic [DUTY_W-1:0] g;
    logic [DUTY_W-1:0] b;
  } duty_t;

  // One saturating INC step on a single channel. The extra top bit catches
  // the borrow on a decrement and the overshoot on an increment.
  function automatic logic [DUTY_W-1:0] sat_step(input logic [DUTY_W-1:0] d,
                                                 input logic              down);
    logic [DUTY_W:0]   x;
    logic [DUTY_W-1:0] res;
    if (down) begin
      x   = {1'b0, d} - INC_X;
      res = x[DUTY_W] ? '0 : x[DUTY_W-1:0];
    end else begin
      x   = {1'b0, d} + INC_X;
      res = (x > MAX_X) ? MAX_D : x[DUTY_W-1:0];
    end
    return res;
  endfunction

  // Duty triple after one advance within segment s: exactly one channel moves.
  function automatic duty_t advance_duty(input duty_t cur, input seg_t s);
    duty_t nxt;
    nxt = cur;
    case (s)
      SEG_R2Y: nxt.g = sat_step(cur.g, 1'b0);
      SEG_Y2G: nxt.r = sat_step(cur.r, 1'b1);
      SEG_G2C: nxt.b = sat_step(cur.b, 1'b0);
      SEG_C2B: nxt.g = sat_step(cur.g, 1'b1);
      SEG_B2M: nxt.r = sat_step(cur.r, 1'b0);
      SEG_M2R: nxt.b = sat_step(cur.b, 1'b1);
      default: nxt = cur;
    endcase
    return nxt;
  endfunction

  seq_state_t       state_q, state_next;
  duty_t            duty_q;
  seg_t             seg_q;
  logic [IDX_W-1:0] idx_q;
  logic             wrap_q;
  logic             ovr_q;

  logic             tick;
  logic             do_adv;
  logic             ovr_set;

  // The prescaler runs whenever run is high, including during OFFER, so the
  // fade period does not stretch with handshake latency. Dropping run clears it.
  tick_prescaler #(
    .DIV (TICK_DIV)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (run),
    .tick  (tick)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_next;
  end

  always_comb begin
    state_next = state_q;
    do_adv     = 1'b0;
    ovr_set    = 1'b0;
    case (state_q)
      IDLE: begin
        if (run) begin
          state_next = WAIT;
        end else if (step) begin
          do_adv     = 1'b1;
          state_next = OFFER;
        end
      end
      WAIT: begin
        if (!run) begin
          state_next = IDLE;
        end else if (tick) begin
          do_adv     = 1'b1;
          state_next = OFFER;
        end
      end
      OFFER: begin
        // Duties must stay stable while offered, so a tick here is lost.
        if (tick) ovr_set = 1'b1;
        if (upd_ready) state_next = run ? WAIT : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      duty_q <= '{r: MAX_D, g: '0, b: '0};
      seg_q  <= SEG_R2Y;
      idx_q  <= '0;
      wrap_q <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      wrap_q <= 1'b0;
      if (do_adv) begin
        duty_q <= advance_duty(duty_q, seg_q);
        if (idx_q == IDX_LAST) begin
          idx_q  <= '0;
          seg_q  <= next_seg(seg_q);
          wrap_q <= (seg_q == SEG_M2R);
        end else begin
          idx_q <= idx_q + IDX_W'(1);
        end
      end
      if (ovr_set)      ovr_q <= 1'b1;
      else if (ovr_clr) ovr_q <= 1'b0;
    end
  end

  // Pure state decode: upd_valid never looks at upd_ready.
  assign upd_valid  = (state_q == OFFER);
  assign duty_r     = duty_q.r;
  assign duty_g     = duty_q.g;
  assign duty_b     = duty_q.b;
  assign seg        = seg_q;
  assign wheel_wrap = wrap_q;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_rgb_wheel_sequencer.sv
// Scoreboard bench for rgb_wheel_sequencer with PWM_INTERVAL=12, STEPS_PER_SEG=4, TICK_DIV=5.
// Stimulus pushes hand-computed duty triples; a negedge monitor pops one per rising upd_valid.
// Direct checks cover reset, timing, overrun, stepping and mid-offer reset.
module tb_rgb_wheel_sequencer;

  localparam int PI  = 12;
  localparam int SPS = 4;
  localparam int TD  = 5;
  localparam int DW  = $clog2(PI + 1);

  typedef struct {
    int r;
    int g;
    int b;
    int s;
    int w;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n, run, step, ovr_clr, upd_ready;
  logic          upd_valid, wheel_wrap, overrun;
  logic [DW-1:0] duty_r, duty_g, duty_b;
  logic [2:0]    seg;

  always #5 clk = ~clk;

  rgb_wheel_sequencer #(
    .PWM_INTERVAL  (PI),
    .STEPS_PER_SEG (SPS),
    .TICK_DIV      (TD)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run),
    .step       (step),
    .ovr_clr    (ovr_clr),
    .upd_ready  (upd_ready),
    .upd_valid  (upd_valid),
    .duty_r     (duty_r),
    .duty_g     (duty_g),
    .duty_b     (duty_b),
    .seg        (seg),
    .wheel_wrap (wheel_wrap),
    .overrun    (overrun)
  );

  // Hand-computed wheel: advance k (0-based) within one 24-advance revolution.
  int tr[24] = '{12,12,12,12,  9, 6, 3, 0,  0, 0, 0, 0,  0, 0, 0, 0,  3, 6, 9,12, 12,12,12,12};
  int tg[24] = '{ 3, 6, 9,12, 12,12,12,12, 12,12,12,12,  9, 6, 3, 0,  0, 0, 0, 0,  0, 0, 0, 0};
  int tb[24] = '{ 0, 0, 0, 0,  0, 0, 0, 0,  3, 6, 9,12, 12,12,12,12, 12,12,12,12,  9, 6, 3, 0};
  int ts[24] = '{ 0, 0, 0, 1,  1, 1, 1, 2,  2, 2, 2, 3,  3, 3, 3, 4,  4, 4, 4, 5,  5, 5, 5, 0};

  int   n_pass   = 0;
  int   n_total  = 0;
  int   cyc      = 0;
  int   adv_cnt  = 0;
  int   wrap_cnt = 0;
  int   run_cyc  = 0;
  int   rise_cyc[64];
  exp_t q[$];
  exp_t cur;
  logic prev_vld = 1'b0;

  function automatic void check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endfunction

  task automatic push_exp(input int k);
    exp_t e;
    e.r = tr[k % 24];
    e.g = tg[k % 24];
    e.b = tb[k % 24];
    e.s = ts[k % 24];
    e.w = ((k % 24) == 23) ? 1 : 0;
    q.push_back(e);
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_adv(input int target, input int budget);
    int n;
    n = 0;
    while (adv_cnt < target && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    check($sformatf("reach_advance_%0d", target), adv_cnt, target);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: one scoreboard entry per rising upd_valid; hold check on handshake.
  always @(negedge clk) begin
    if (upd_valid && !prev_vld) begin
      if (q.size() == 0) begin
        check("spurious_update_queue_depth", q.size(), 1);
      end else begin
        cur = q.pop_front();
        check($sformatf("adv%0d_r", adv_cnt + 1), int'(duty_r), cur.r);
        check($sformatf("adv%0d_g", adv_cnt + 1), int'(duty_g), cur.g);
        check($sformatf("adv%0d_b", adv_cnt + 1), int'(duty_b), cur.b);
        check($sformatf("adv%0d_seg", adv_cnt + 1), int'(seg), cur.s);
        check($sformatf("adv%0d_wrap", adv_cnt + 1), int'(wheel_wrap), cur.w);
      end
      if (adv_cnt < 64) rise_cyc[adv_cnt] = cyc;
      adv_cnt++;
    end else if (wheel_wrap) begin
      check("wrap_outside_offer_start", int'(wheel_wrap), 0);
    end
    if (upd_valid && upd_ready)
      check("duties_held_to_handshake", int'({duty_r, duty_g, duty_b}),
            (cur.r << 8) | (cur.g << 4) | cur.b);
    if (wheel_wrap) wrap_cnt++;
    prev_vld = upd_valid;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation still running at t=%0t, expected finish", $time);
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; run = 1'b0; step = 1'b0; ovr_clr = 1'b0; upd_ready = 1'b0;
    repeat (3) cycle();
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_upd_valid", int'(upd_valid), 0);
    check("rst_duty_r", int'(duty_r), 12);
    check("rst_duty_g", int'(duty_g), 0);
    check("rst_duty_b", int'(duty_b), 0);
    check("rst_seg", int'(seg), 0);
    check("rst_wheel_wrap", int'(wheel_wrap), 0);
    check("rst_overrun", int'(overrun), 0);

    // Free-running fade, one full wheel with ready tied high.
    cycle();
    upd_ready = 1'b1;
    run       = 1'b1;
    run_cyc   = cyc;
    for (int k = 0; k < 24; k++) push_exp(k);
    wait_adv(24, 200);
    check("first_valid_latency", rise_cyc[0] - run_cyc, 5);
    check("interval_1_2", rise_cyc[1] - rise_cyc[0], 5);
    check("interval_2_3", rise_cyc[2] - rise_cyc[1], 5);
    check("interval_23_24", rise_cyc[23] - rise_cyc[22], 5);
    check("wrap_count_after_wheel", wrap_cnt, 1);

    // Paused single-stepping from R=12, G=0, B=0.
    cycle();
    run = 1'b0;
    repeat (3) cycle();
    for (int k = 24; k < 27; k++) push_exp(k);
    for (int i = 0; i < 3; i++) begin
      step = 1'b1;
      cycle();
      step = 1'b0;
      repeat (3) cycle();
    end
    wait_adv(27, 20);
    check("step_duty_g", int'(duty_g), 9);
    check("step_duty_r", int'(duty_r), 12);
    check("step_duty_b", int'(duty_b), 0);
    check("step_seg", int'(seg), 0);

    // step together with run=1 must not advance.
    upd_ready = 1'b0;
    run       = 1'b1;
    step      = 1'b1;
    push_exp(27);
    cycle();
    step = 1'b0;
    cycle();
    check("step_with_run_no_advance", adv_cnt, 27);
    check("step_with_run_no_valid", int'(upd_valid), 0);

    // Backpressure: ready low for 12 cycles after the offer.
    wait_adv(28, 40);
    repeat (12) cycle();
    check("bp_valid_held", int'(upd_valid), 1);
    check("bp_duty_r_held", int'(duty_r), 12);
    check("bp_duty_g_held", int'(duty_g), 12);
    check("bp_overrun_set", int'(overrun), 1);
    upd_ready = 1'b1;
    push_exp(28);
    wait_adv(29, 40);
    check("bp_next_interval", rise_cyc[28] - rise_cyc[27], 15);
    check("overrun_sticky", int'(overrun), 1);
    ovr_clr = 1'b1;
    cycle();
    ovr_clr = 1'b0;
    @(negedge clk);
    check("overrun_cleared", int'(overrun), 0);

    // Reset asserted while an offer is pending.
    upd_ready = 1'b0;
    push_exp(29);
    wait_adv(30, 40);
    repeat (6) cycle();
    check("pre_reset_valid", int'(upd_valid), 1);
    check("pre_reset_overrun", int'(overrun), 1);
    rst_n = 1'b0;
    run   = 1'b0;
    cycle();
    rst_n = 1'b1;
    @(negedge clk);
    check("mid_offer_rst_valid", int'(upd_valid), 0);
    check("mid_offer_rst_r", int'(duty_r), 12);
    check("mid_offer_rst_g", int'(duty_g), 0);
    check("mid_offer_rst_b", int'(duty_b), 0);
    check("mid_offer_rst_seg", int'(seg), 0);
    check("mid_offer_rst_overrun", int'(overrun), 0);
    repeat (8) cycle();
    check("final_advance_count", adv_cnt, 30);
    check("final_queue_empty", q.size(), 0);
    check("final_wrap_count", wrap_cnt, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/rgb_wheel_sequencer.md
# rgb_wheel_sequencer

Synchronous controller that sequences the RGB colour-wheel fade: a tick prescaler, a six-segment hue state machine and a per-channel duty calculator. It hands each new duty triple to the PWM channel bank over a valid/ready handshake, so the bank latches new values only at its own period boundary. Run, pause and single-step controls sit here. All logic is on `clk`; no derived clocks are used.

## Interface
- `PWM_INTERVAL`, 1200: full-scale duty (100 µs at 12 MHz).
- `STEPS_PER_SEG`, 100: duty steps per hue segment; must divide `PWM_INTERVAL` exactly.
- `TICK_DIV`, 20000: `clk` cycles per step tick.
- `DUTY_W`, `$clog2(PWM_INTERVAL+1)`: duty width (derived).
- `clk` in 1: system clock, 12 MHz.
- `rst_n` in 1: reset, synchronous, active-low.
- `run` in 1: level; 1 = free-running fade, 0 = paused.
- `step` in 1: one-cycle pulse; advances one step while paused.
- `ovr_clr` in 1: clears `overrun`.
- `upd_ready` in 1: PWM bank accepts the offered triple.
- `upd_valid` out 1: duty triple offered.
- `duty_r`, `duty_g`, `duty_b` out `DUTY_W`: duty targets.
- `seg` out 3: current hue segment, 0..5.
- `wheel_wrap` out 1: one-cycle pulse on the segment 5→0 rollover.
- `overrun` out 1: sticky flag; a tick was dropped.

## Operation
- Reset values: `duty_r`=`PWM_INTERVAL`; `duty_g`=`duty_b`=0; `seg`=0; step index 0; prescaler 0; `upd_valid`=0; `wheel_wrap`=0; `overrun`=0; state IDLE.
- INC = `PWM_INTERVAL`/`STEPS_PER_SEG` (12 by default).
- Prescaler:
  - Counts 0..`TICK_DIV`-1 while `run`=1 and wraps.
  - Held at 0 while `run`=0.
  - tick = (count == `TICK_DIV`-1).
- States:
  - IDLE: `run`=1 → WAIT. `run`=0 and `step`=1 → advance, then OFFER.
  - WAIT: tick → advance, then OFFER. `run`=0 → IDLE, prescaler cleared.
  - OFFER: `upd_valid`=1 and duties held stable. On `upd_valid`&&`upd_ready` → WAIT if `run`=1, else IDLE.
- Advance, one register update, by `seg`:
  - 0: G+=INC
  - 1: R-=INC
  - 2: B+=INC
  - 3: G-=INC
  - 4: R+=INC
  - 5: B-=INC
- All duty arithmetic saturates to [0, `PWM_INTERVAL`]. The add/subtract uses `DUTY_W`+1 bits before the clamp.
- Step index:
  - Increments on every advance.
  - At `STEPS_PER_SEG`-1 it returns to 0 and `seg` increments (5→0).
  - On the 5→0 transition `wheel_wrap` pulses in the same cycle that `upd_valid` rises.
- One full wheel is 6·`STEPS_PER_SEG` advances. Afterwards the duties are exactly R=max, G=B=0.
- Tick while in OFFER: the tick is dropped, `overrun` is set and no duty change occurs.
- `step` in WAIT or OFFER, or with `run`=1: ignored.
- `run` falling during OFFER: the handshake still completes, then the block enters IDLE.
- `overrun`:
  - Cleared by `ovr_clr`.
  - If a set and `ovr_clr` occur in the same cycle, set wins.

## Timing
- Tick (or `step`) seen in cycle N → new duties, `upd_valid`=1 and `seg`/`wheel_wrap` all visible after edge N+1.
- `upd_valid` falls on the edge after the cycle where `upd_valid`&&`upd_ready`.
- With `upd_ready` tied high, `upd_valid` is a one-cycle pulse.
- `upd_valid` must not depend combinationally on `upd_ready`.
- `upd_ready` high while `upd_valid`=0 has no effect.
- The prescaler keeps running in OFFER. Fade period is `TICK_DIV`·`STEPS_PER_SEG`·6 cycles (12 000 000 by default, 1 s) provided each handshake completes within `TICK_DIV` cycles.
- `rst_n` low, including mid-OFFER: all outputs take their reset values on the next edge.

## Structure
- Shared package `fade_pkg` holds:
  - `seg_t` enum: SEG_R2Y, SEG_Y2G, SEG_G2C, SEG_C2B, SEG_B2M, SEG_M2R.
  - `seq_state_t` enum: IDLE, WAIT, OFFER.
  - Segment count constant 6.
- Sub-module `tick_prescaler`:
  - Parameter `DIV`; inputs `clk`, `rst_n`, `en`; output `tick`.
  - Counter is cleared when `en`=0.
- Duty calculation is a function inside the sequencer.

## Test plan
Bench parameters are `PWM_INTERVAL`=12, `STEPS_PER_SEG`=4, `TICK_DIV`=5 (INC=3).
- Reset, then `run`=1 with `upd_ready`=1:
  - First `upd_valid` appears 5 cycles after `run` rises, with R=12, G=3, B=0, `seg`=0.
  - Afterwards one update every 5 cycles.
- Continue 24 advances:
  - Duty sequence matches the segment table.
  - `seg` goes 0→5.
  - `wheel_wrap` pulses once on advance 24, with R=12, G=0, B=0, `seg`=0.
- `upd_ready`=0 for 12 cycles after a valid:
  - Duties are held.
  - `overrun`=1 after the next tick.
  - No skipped step once ready returns.
  - `ovr_clr` then clears `overrun`.
- `run`=0, then three `step` pulses spaced 4 cycles apart with ready high:
  - Exactly 3 advances; G=9.
  - `step` while `run`=1 gives no extra advance.
- `rst_n` low for 1 cycle during OFFER: after the next edge, `upd_valid`=0, R=12, G=B=0, `seg`=0, `overrun`=0.
